// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The datapath (master) reports its events; the sequencer (slave)
// returns hold, bubble and redirect controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Events from the pipeline
  logic             Iwait;
  logic             Dwait;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_dst;
  logic             ex_is_load;
  logic             ex_regwrite;
  logic             ex_mdu_start;
  logic             ex_mdu_is_div;
  logic             ex_redirect;
  logic [63:0]      ex_redirect_pc;
  // Controls back to the pipeline
  logic             stall_F;
  logic             stall_FD;
  logic             flush_FD;
  logic             flush_DE;
  logic             exe_is_waiting;
  logic             pc_redirect_valid;
  logic [63:0]      pc_redirect;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output Iwait, Dwait, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_dst,
           ex_is_load, ex_regwrite, ex_mdu_start, ex_mdu_is_div,
           ex_redirect, ex_redirect_pc,
    input  stall_F, stall_FD, flush_FD, flush_DE, exe_is_waiting,
           pc_redirect_valid, pc_redirect, stall_count
  );

  modport slave (
    input  Iwait, Dwait, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_dst,
           ex_is_load, ex_regwrite, ex_mdu_start, ex_mdu_is_div,
           ex_redirect, ex_redirect_pc,
    output stall_F, stall_FD, flush_FD, flush_DE, exe_is_waiting,
           pc_redirect_valid, pc_redirect, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Arbitrates memory waits,
// load-use hazards, multi-cycle MDU ops and EX redirects into IF/ID and ID/EX
// hold/bubble controls plus a PC redirect, and counts PC-stall cycles.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int MC_W       = $clog2(MAX_CYCLES + 1);
  // Counter reload is N-2: the start cycle itself already holds EX once.
  localparam logic [MC_W-1:0] MUL_RELOAD = (MUL_CYCLES > 1) ? MC_W'(MUL_CYCLES - 2) : '0;
  localparam logic [MC_W-1:0] DIV_RELOAD = (DIV_CYCLES > 1) ? MC_W'(DIV_CYCLES - 2) : '0;
  localparam logic            MUL_MULTI  = (MUL_CYCLES > 1);
  localparam logic            DIV_MULTI  = (DIV_CYCLES > 1);

  typedef enum logic [1:0] {RUN, EXE_WAIT, REDIR_WAIT} state_e;

  state_e           state_q, state_d;
  logic [MC_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [63:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        load_use;
  logic        busy;
  logic        mdu_multi;
  logic        stall_f, stall_fd, flush_fd, flush_de, exe_wait, redir_vld;
  logic [63:0] redir_pc;

  assign mdu_multi = hz.ex_mdu_is_div ? DIV_MULTI : MUL_MULTI;

  assign load_use = hz.ex_is_load && hz.ex_regwrite && (hz.ex_dst != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_dst)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_dst)));

  // Next-state and control outputs: MDU hold first (it feeds busy), then the
  // priority chain of hold > redirect > fetch wait > load-use.
  always_comb begin
    state_d    = state_q;
    mdu_cnt_d  = mdu_cnt_q;
    redir_pc_d = redir_pc_q;
    stall_f    = 1'b0;
    stall_fd   = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    exe_wait   = 1'b0;
    redir_vld  = 1'b0;
    redir_pc   = 64'd0;
    busy       = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.ex_mdu_start && !hz.Dwait && mdu_multi) begin
          exe_wait  = 1'b1;
          mdu_cnt_d = hz.ex_mdu_is_div ? DIV_RELOAD : MUL_RELOAD;
          state_d   = EXE_WAIT;
        end
      end
      EXE_WAIT: begin
        exe_wait = (mdu_cnt_q != '0);
        if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - MC_W'(1);
        else                 state_d   = RUN;
      end
      default: ;
    endcase

    busy = hz.Dwait || exe_wait;

    if (state_q == REDIR_WAIT) begin
      // Keep fetch frozen and squash the wrong-path fetch until it lands.
      stall_f  = 1'b1;
      flush_fd = 1'b1;
      flush_de = !busy;
      if (!hz.Iwait) begin
        redir_vld = 1'b1;
        redir_pc  = redir_pc_q;
        state_d   = RUN;
      end
    end else if (busy) begin
      // EX frozen: a pending redirect stays in EX and is taken later.
      stall_f  = 1'b1;
      stall_fd = 1'b1;
    end else if (hz.ex_redirect && !hz.Iwait) begin
      redir_vld = 1'b1;
      redir_pc  = hz.ex_redirect_pc;
      flush_fd  = 1'b1;
      flush_de  = 1'b1;
    end else if (hz.ex_redirect) begin
      redir_pc_d = hz.ex_redirect_pc;
      flush_de   = 1'b1;
      stall_f    = 1'b1;
      state_d    = REDIR_WAIT;
    end else if (hz.Iwait || load_use) begin
      stall_f  = 1'b1;
      stall_fd = 1'b1;
      flush_de = 1'b1;
    end

    stall_cnt_d = (stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  // State, MDU counter, redirect latch and stall counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      mdu_cnt_q   <= '0;
      redir_pc_q  <= 64'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      redir_pc_q  <= redir_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is low both pipeline registers are bubbled and nothing else acts.
  assign hz.stall_F           = reset_n && stall_f;
  assign hz.stall_FD          = reset_n && stall_fd;
  assign hz.flush_FD          = !reset_n || flush_fd;
  assign hz.flush_DE          = !reset_n || flush_de;
  assign hz.exe_is_waiting    = reset_n && exe_wait;
  assign hz.pc_redirect_valid = reset_n && redir_vld;
  assign hz.pc_redirect       = reset_n ? redir_pc : 64'd0;
  assign hz.stall_count       = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MUL_CYCLES=1, DIV_CYCLES=16,
// CNT_W=4). Expected controls are queued per cycle and checked on the
// falling edge; stall_count expectations come from a small saturating model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_hazard_ctrl #(
    .MUL_CYCLES(1),
    .DIV_CYCLES(16),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(bus)
  );

  typedef struct {
    string       tag;
    logic [5:0]  ctl;   // {stall_F, stall_FD, flush_FD, flush_DE, exe_is_waiting, pc_redirect_valid}
    logic [63:0] pc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] model_cnt = 4'd0;

  task automatic idle();
    bus.Iwait = 0; bus.Dwait = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_dst = 0; bus.ex_is_load = 0; bus.ex_regwrite = 0;
    bus.ex_mdu_start = 0; bus.ex_mdu_is_div = 0;
    bus.ex_redirect = 0; bus.ex_redirect_pc = 64'd0;
  endtask

  task automatic push(input string tag, input logic [5:0] ctl, input logic [63:0] pc);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.pc = pc; e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [5:0] obs;
    e = sb.pop_front();
    obs = {bus.stall_F, bus.stall_FD, bus.flush_FD, bus.flush_DE,
           bus.exe_is_waiting, bus.pc_redirect_valid};
    total++;
    assert (obs === e.ctl) else begin
      bad++;
      $error("FAIL %s ctl{sF,sFD,fFD,fDE,ew,rv} got=%b want=%b", e.tag, obs, e.ctl);
    end
    total++;
    assert (bus.pc_redirect === e.pc) else begin
      bad++;
      $error("FAIL %s pc_redirect got=%h want=%h", e.tag, bus.pc_redirect, e.pc);
    end
    total++;
    assert (bus.stall_count === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_count got=%0d want=%0d", e.tag, bus.stall_count, e.cnt);
    end
  endtask

  // One clocked cycle: queue expectation, check mid-cycle, advance, update model.
  task automatic cyc(input string tag, input logic [5:0] ctl, input logic [63:0] pc);
    push(tag, ctl, pc);
    @(negedge clk);
    pop_check();
    if (ctl[5] && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    model_cnt = 4'd0;
    push(tag, 6'b001100, 64'd0);
    #1;
    pop_check();
  endtask

  // Full divide: 15 held cycles then release on the 16th.
  task automatic run_div(input string tag);
    bus.ex_mdu_start = 1; bus.ex_mdu_is_div = 1;
    for (int i = 1; i <= 15; i++) cyc(tag, 6'b110010, 64'd0);
    cyc({tag, "_last"}, 6'b000000, 64'd0);
    idle();
  endtask

  initial begin
    idle();
    // Reset state
    reset_check("reset");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    cyc("idle", 6'b000000, 64'd0);

    // Load-use on rs1, then EX bubble
    bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_dst = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    cyc("lu_rs1", 6'b110100, 64'd0);
    idle();
    cyc("lu_after", 6'b000000, 64'd0);
    // x0 destination never hazards
    bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_dst = 0; bus.id_use_rs1 = 1;
    cyc("lu_x0", 6'b000000, 64'd0);
    // rs2 match but not used, then used
    bus.ex_dst = 9; bus.id_rs2 = 9; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    cyc("lu_rs2_unused", 6'b000000, 64'd0);
    bus.id_use_rs2 = 1;
    cyc("lu_rs2", 6'b110100, 64'd0);
    bus.ex_is_load = 0;
    cyc("lu_not_load", 6'b000000, 64'd0);
    idle();

    // Divide holds EX for 15 cycles; single-cycle multiply never holds
    run_div("div");
    bus.ex_mdu_start = 1; bus.ex_mdu_is_div = 0;
    for (int i = 0; i < 3; i++) cyc("mul1", 6'b000000, 64'd0);
    idle();

    // Redirect during busy fetch
    bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h8000_0040; bus.Iwait = 1;
    cyc("redir_latch", 6'b100100, 64'd0);
    bus.ex_redirect = 0; bus.ex_redirect_pc = 64'hDEAD_BEEF_0000_0000;
    for (int i = 0; i < 3; i++) cyc("redir_wait", 6'b101100, 64'd0);
    bus.Iwait = 0;
    cyc("redir_issue", 6'b101101, 64'h8000_0040);
    idle();
    cyc("redir_done", 6'b000000, 64'd0);

    // Immediate redirect with idle fetch
    bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h0000_0000_0000_1000;
    cyc("redir_now", 6'b001101, 64'h1000);
    idle();

    // Redirect wait with a data wait: ID/EX held, no bubble
    bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h0000_0000_0000_2000; bus.Iwait = 1;
    cyc("rw_latch", 6'b100100, 64'd0);
    bus.ex_redirect = 0; bus.Dwait = 1;
    cyc("rw_dwait", 6'b101000, 64'd0);
    bus.Dwait = 0; bus.Iwait = 0;
    cyc("rw_issue", 6'b101101, 64'h2000);
    idle();

    // Dwait dominates a pending redirect
    bus.Dwait = 1; bus.ex_redirect = 1; bus.ex_redirect_pc = 64'h1234;
    for (int i = 0; i < 4; i++) cyc("dw_hold", 6'b110000, 64'd0);
    bus.Dwait = 0;
    cyc("dw_redir", 6'b001101, 64'h1234);
    idle();

    // Reset in the middle of a divide (counter = 7)
    bus.ex_mdu_start = 1; bus.ex_mdu_is_div = 1;
    for (int i = 1; i <= 8; i++) cyc("div_pre", 6'b110010, 64'd0);
    push("div_cnt7", 6'b110010, 64'd0);
    pop_check();
    reset_n = 1'b0;
    reset_check("reset_mid");
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    cyc("post_reset_idle", 6'b000000, 64'd0);
    run_div("div_post");

    // Stall counter saturation
    reset_n = 1'b0;
    reset_check("reset_sat");
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.Iwait = 1;
    for (int i = 0; i < 20; i++) cyc("iwait", 6'b110100, 64'd0);
    bus.Iwait = 0;
    cyc("sat_after", 6'b000000, 64'd0);
    total++;
    assert (bus.stall_count === 4'd15) else begin
      bad++;
      $error("FAIL sat_final stall_count got=%0d want=15", bus.stall_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
